// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit.
// Pure declarations: no logic, no latency.
// Opcodes, FSM state encoding, datapath mux selects and trap causes.
package ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [1:0] PC_PLUS4   = 2'b00;
    localparam logic [1:0] PC_ALUOUT  = 2'b01;
    localparam logic [1:0] PC_JALR    = 2'b10;

    localparam logic [1:0] SRC_A_RS1  = 2'b00;
    localparam logic [1:0] SRC_A_PC   = 2'b01;
    localparam logic [1:0] SRC_A_ZERO = 2'b10;

    localparam logic       SRC_B_RS2  = 1'b0;
    localparam logic       SRC_B_IMM  = 1'b1;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_CMP    = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;

    localparam logic [1:0] WB_ALUOUT  = 2'b00;
    localparam logic [1:0] WB_MEM     = 2'b01;
    localparam logic [1:0] WB_PC4     = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_IMEM_TO = 2'b10;
    localparam logic [1:0] CAUSE_DMEM_TO = 2'b11;

    typedef struct packed {
        logic r;
        logic op_imm;
        logic lui;
        logic auipc;
        logic load;
        logic store;
        logic branch;
        logic jal;
        logic jalr;
    } opclass_t;

endpackage

// File: rtl/opclass_decode.sv
// Opcode to one-hot instruction class plus illegal flag.
// Purely combinational, zero latency.
// No handshake; result is valid whenever the opcode is.
module opclass_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output opclass_t   cls,
    output logic       illegal
);

    always_comb begin
        cls = '0;
        case (opcode)
            OPC_OP:     cls.r      = 1'b1;
            OPC_OP_IMM: cls.op_imm = 1'b1;
            OPC_LUI:    cls.lui    = 1'b1;
            OPC_AUIPC:  cls.auipc  = 1'b1;
            OPC_LOAD:   cls.load   = 1'b1;
            OPC_STORE:  cls.store  = 1'b1;
            OPC_BRANCH: cls.branch = 1'b1;
            OPC_JAL:    cls.jal    = 1'b1;
            OPC_JALR:   cls.jalr   = 1'b1;
            default:    cls        = '0;
        endcase
        illegal = ~|cls;
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with imem/dmem req/ack.
// CPI 3 (branch/jumps), 4 (ALU/LUI/AUIPC/store), 5 (load) plus memory wait cycles.
// Requests hold until ack; a watchdog traps a stalled handshake, trap is sticky until reset.
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] instr_opcode,
    input  logic       imem_ack,
    input  logic       dmem_ack,
    input  logic       branch_taken,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_sel,
    output logic [1:0] alu_src_a,
    output logic       alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       retire,
    output logic       trap,
    output logic [1:0] trap_cause
);

    // A zero-width counter is not legal, so the watchdog-off build keeps one idle bit.
    localparam int CW = (CNT_W > 0) ? CNT_W : 1;
    localparam logic [CW-1:0] WD_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    state_t        state, state_d;
    logic [6:0]    op_q;
    logic [6:0]    dec_opcode;
    logic [CW-1:0] wd_cnt, wd_cnt_d;
    logic [1:0]    cause_q, cause_d;
    logic          wd_expire;
    opclass_t      cls;
    logic          illegal;

    // One decoder serves both DECODE (live opcode) and later states (latched opcode).
    assign dec_opcode = (state == ST_DECODE) ? instr_opcode : op_q;

    opclass_decode u_opclass_decode (
        .opcode  (dec_opcode),
        .cls     (cls),
        .illegal (illegal)
    );

    assign wd_expire = (TIMEOUT > 0) && (wd_cnt == WD_LAST);

    always_comb begin
        state_d   = state;
        cause_d   = cause_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_sel    = PC_PLUS4;
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        alu_op    = ALU_ADD;
        reg_write = 1'b0;
        wb_sel    = WB_ALUOUT;
        retire    = 1'b0;

        case (state)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_write = 1'b1;
                    state_d  = ST_DECODE;
                end else if (wd_expire) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_IMEM_TO;
                end
            end

            ST_DECODE: begin
                if (illegal) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    // PC + imm lands in ALUOut for branch/JAL targets.
                    alu_src_a = SRC_A_PC;
                    alu_src_b = SRC_B_IMM;
                    alu_op    = ALU_ADD;
                    state_d   = ST_EXEC;
                end
            end

            ST_EXEC: begin
                if (cls.r) begin
                    alu_op  = ALU_FUNCT;
                    state_d = ST_WB;
                end else if (cls.op_imm) begin
                    alu_src_b = SRC_B_IMM;
                    alu_op    = ALU_FUNCT;
                    state_d   = ST_WB;
                end else if (cls.lui) begin
                    alu_src_a = SRC_A_ZERO;
                    alu_src_b = SRC_B_IMM;
                    state_d   = ST_WB;
                end else if (cls.auipc) begin
                    alu_src_a = SRC_A_PC;
                    alu_src_b = SRC_B_IMM;
                    state_d   = ST_WB;
                end else if (cls.load || cls.store) begin
                    alu_src_b = SRC_B_IMM;
                    state_d   = ST_MEM;
                end else if (cls.branch) begin
                    alu_op   = ALU_CMP;
                    pc_write = 1'b1;
                    pc_sel   = branch_taken ? PC_ALUOUT : PC_PLUS4;
                    retire   = 1'b1;
                    state_d  = ST_FETCH;
                end else if (cls.jal) begin
                    pc_write  = 1'b1;
                    pc_sel    = PC_ALUOUT;
                    reg_write = 1'b1;
                    wb_sel    = WB_PC4;
                    retire    = 1'b1;
                    state_d   = ST_FETCH;
                end else if (cls.jalr) begin
                    alu_src_b = SRC_B_IMM;
                    pc_write  = 1'b1;
                    pc_sel    = PC_JALR;
                    reg_write = 1'b1;
                    wb_sel    = WB_PC4;
                    retire    = 1'b1;
                    state_d   = ST_FETCH;
                end else begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            end

            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = cls.store;
                if (dmem_ack) begin
                    if (cls.store) begin
                        pc_write = 1'b1;
                        pc_sel   = PC_PLUS4;
                        retire   = 1'b1;
                        state_d  = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (wd_expire) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_DMEM_TO;
                end
            end

            ST_WB: begin
                reg_write = 1'b1;
                wb_sel    = cls.load ? WB_MEM : WB_ALUOUT;
                pc_write  = 1'b1;
                pc_sel    = PC_PLUS4;
                retire    = 1'b1;
                state_d   = ST_FETCH;
            end

            ST_TRAP: state_d = ST_TRAP;

            default: state_d = ST_FETCH;
        endcase
    end

    // Counts wait cycles of the current handshake; any state change starts it afresh.
    always_comb begin
        wd_cnt_d = wd_cnt;
        if (state_d != state) begin
            wd_cnt_d = '0;
        end else if ((TIMEOUT > 0) && (state == ST_FETCH || state == ST_MEM)) begin
            wd_cnt_d = wd_cnt + CW'(1);
        end
    end

    assign trap       = (state == ST_TRAP);
    assign trap_cause = cause_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_FETCH;
            op_q    <= '0;
            wd_cnt  <= '0;
            cause_q <= CAUSE_NONE;
        end else begin
            state   <= state_d;
            wd_cnt  <= wd_cnt_d;
            cause_q <= cause_d;
            if (state == ST_DECODE) begin
                op_q <= instr_opcode;
            end
        end
    end

endmodule
